// File: rtl/ate_blk_streamer.sv
// ate_blk_streamer
// Transmit side of the adaptive-threshold pixel stream. Reads a raster-ordered
// 8-bit image from a synchronous-read memory and replays it one pixel per clock
// in 8x8 block order: row-major inside a block, blocks left-to-right then
// top-to-bottom. Framing strobes sob/sof mark the first pixel of every block
// and of the frame.
//
// Optional build macro: ATE_STREAM_LOOP_EN
//   defined   - the stream wraps from the last address straight back to
//               block 0 / pixel 0 forever; done pulses once per frame.
//   undefined - one frame per start, followed by a one-cycle flush and done.

module ate_blk_streamer #(
    parameter int BLK_X = 6,
    parameter int BLK_Y = 4,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    pix_data,
    output logic          pix_valid,
    output logic          sob,
    output logic          sof,
    output logic          busy,
    output logic          done
);

    localparam int BXW        = (BLK_X > 1) ? $clog2(BLK_X) : 1;
    localparam int BYW        = (BLK_Y > 1) ? $clog2(BLK_Y) : 1;
    localparam int ROW_STRIDE = 8 * BLK_X;

    // Address deltas for the incremental generator:
    //   next row inside a block  : + stride - 7
    //   next block along the row : - 7*stride + 1  (applied as a subtraction)
    localparam logic [AW-1:0]  STEP_ROW      = AW'(ROW_STRIDE - 7);
    localparam logic [AW-1:0]  STEP_BLK_BACK = AW'(7 * ROW_STRIDE - 1);
    localparam logic [BXW-1:0] BX_MAX        = BXW'(BLK_X - 1);
    localparam logic [BYW-1:0] BY_MAX        = BYW'(BLK_Y - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]     rx;
    logic [2:0]     ry;
    logic [BXW-1:0] bx;
    logic [BYW-1:0] by;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  addr_next;

    logic last_rx;
    logic last_ry;
    logic last_bx;
    logic last_by;
    logic frame_last;

    logic       last_pix_q;
    logic [7:0] pix_hold;

    assign last_rx    = (rx == 3'd7);
    assign last_ry    = (ry == 3'd7);
    assign last_bx    = (bx == BX_MAX);
    assign last_by    = (by == BY_MAX);
    assign frame_last = last_rx && last_ry && last_bx && last_by;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; in loop mode the last address simply rolls over in RUN
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (frame_last) begin
`ifdef ATE_STREAM_LOOP_EN
                    state_next = RUN;
`else
                    state_next = FLUSH;
`endif
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: read strobe only while issuing addresses, busy outside IDLE
    always_comb begin
        mem_en   = 1'b0;
        busy     = 1'b0;
        mem_addr = addr_q;
        case (state)
            RUN: begin
                mem_en = 1'b1;
                busy   = 1'b1;
            end
            FLUSH: begin
                busy = 1'b1;
            end
            default: begin
                mem_en = 1'b0;
                busy   = 1'b0;
            end
        endcase
    end

    // Address for the following cycle, built from adds/subtracts of constants
    always_comb begin
        addr_next = addr_q + AW'(1);
        if (last_rx) begin
            if (!last_ry) begin
                addr_next = addr_q + STEP_ROW;
            end else if (!last_bx) begin
                addr_next = addr_q - STEP_BLK_BACK;
            end else if (!last_by) begin
                addr_next = addr_q + AW'(1);
            end else begin
                addr_next = '0;
            end
        end
    end

    // Block/pixel counters and the running raster address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx     <= '0;
            ry     <= '0;
            bx     <= '0;
            by     <= '0;
            addr_q <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                rx     <= '0;
                ry     <= '0;
                bx     <= '0;
                by     <= '0;
                addr_q <= '0;
            end
        end else if (state == RUN) begin
            addr_q <= addr_next;
            rx     <= rx + 3'd1;
            if (last_rx) begin
                ry <= ry + 3'd1;
                if (last_ry) begin
                    bx <= last_bx ? '0 : bx + BXW'(1);
                    if (last_bx) begin
                        by <= last_by ? '0 : by + BYW'(1);
                    end
                end
            end
        end
    end

    // Address-phase flags delayed one cycle so they line up with the read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid  <= 1'b0;
            sob        <= 1'b0;
            sof        <= 1'b0;
            last_pix_q <= 1'b0;
            done       <= 1'b0;
        end else begin
            pix_valid  <= (state == RUN);
            sob        <= (state == RUN) && (rx == 3'd0) && (ry == 3'd0);
            sof        <= (state == RUN) && (rx == 3'd0) && (ry == 3'd0)
                          && (bx == '0) && (by == '0);
            last_pix_q <= (state == RUN) && frame_last;
            done       <= last_pix_q;
        end
    end

    // Keeps the last streamed pixel so pix_data is stable while pix_valid is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_hold <= '0;
        end else if (pix_valid) begin
            pix_hold <= mem_rdata;
        end
    end

    // Memory read data is the pixel register; it is only used after a read
    always_comb begin
        pix_data = pix_valid ? mem_rdata : pix_hold;
    end

endmodule
